// File: rtl/cpu_pkg.sv
// Shared decode constants, ALU opcode encodings and the ID/EX control bundle
// used by the decode stage of the five-stage pipeline.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic       shift;
    logic [3:0] aluc;
  } idex_ctrl_t;

endpackage

// File: rtl/id_fwd_mux.sv
// Priority operand select for one register-file read port:
// r0 -> EX (non-load) -> MEM (load data or ALU) -> WB -> register file.
module id_fwd_mux #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] r_i,
  input  logic [DW-1:0] q_i,
  input  logic          ex_wreg_i,
  input  logic          ex_m2reg_i,
  input  logic [AW-1:0] ex_rn_i,
  input  logic [DW-1:0] ex_alu_i,
  input  logic          mem_wreg_i,
  input  logic          mem_m2reg_i,
  input  logic [AW-1:0] mem_rn_i,
  input  logic [DW-1:0] mem_alu_i,
  input  logic [DW-1:0] mem_mo_i,
  input  logic          wb_wreg_i,
  input  logic [AW-1:0] wb_rn_i,
  input  logic [DW-1:0] wb_d_i,
  output logic [DW-1:0] d_o
);

  always_comb begin
    d_o = q_i;
    if (r_i == '0) begin
      d_o = '0;
    end else if (ex_wreg_i && !ex_m2reg_i && (ex_rn_i == r_i)) begin
      d_o = ex_alu_i;
    end else if (mem_wreg_i && (mem_rn_i == r_i)) begin
      d_o = mem_m2reg_i ? mem_mo_i : mem_alu_i;
    end else if (wb_wreg_i && (wb_rn_i == r_i)) begin
      // Register file writes on the edge that ends this cycle, so qa/qb are stale.
      d_o = wb_d_i;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decode, operand forwarding, load-use stall,
// branch resolution in ID and the ID/EX pipeline register.
module id_stage
  import cpu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [31:0]   inst,
  input  logic [DW-1:0] pc4,
  output logic [AW-1:0] rna,
  output logic [AW-1:0] rnb,
  input  logic [DW-1:0] qa,
  input  logic [DW-1:0] qb,
  input  logic          ex_wreg,
  input  logic          ex_m2reg,
  input  logic [AW-1:0] ex_rn,
  input  logic [DW-1:0] ex_alu,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic [AW-1:0] mem_rn,
  input  logic [DW-1:0] mem_alu,
  input  logic [DW-1:0] mem_mo,
  input  logic          wb_wreg,
  input  logic [AW-1:0] wb_rn,
  input  logic [DW-1:0] wb_d,
  output logic          stall,
  output logic          br_taken,
  output logic [DW-1:0] br_target,
  output logic          e_wreg,
  output logic          e_m2reg,
  output logic          e_wmem,
  output logic          e_aluimm,
  output logic          e_shift,
  output logic [3:0]    e_aluc,
  output logic [DW-1:0] e_a,
  output logic [DW-1:0] e_b,
  output logic [DW-1:0] e_imm,
  output logic [AW-1:0] e_rn,
  output logic [DW-1:0] e_pc4
);

  logic [5:0]    op, fn;
  logic [AW-1:0] rs, rt, rd, dest;
  logic [DW-1:0] fwd_a, fwd_b, sext_imm, zext_imm, imm_ext;
  logic          wr_en, uses_rs, uses_rt, use_sext, is_beq, is_bne;
  idex_ctrl_t    dec;

  idex_ctrl_t    ctrl_d, ctrl_q;
  logic [DW-1:0] a_d, a_q, b_d, b_q, imm_d, imm_q, pc4_d, pc4_q;
  logic [AW-1:0] rn_d, rn_q;

  assign op  = inst[31:26];
  assign fn  = inst[5:0];
  assign rs  = inst[25:21];
  assign rt  = inst[20:16];
  assign rd  = inst[15:11];
  assign rna = rs;
  assign rnb = rt;

  assign sext_imm = {{(DW-16){inst[15]}}, inst[15:0]};
  assign zext_imm = {{(DW-16){1'b0}}, inst[15:0]};
  assign imm_ext  = use_sext ? sext_imm : zext_imm;

  id_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .r_i(rs), .q_i(qa),
    .ex_wreg_i(ex_wreg), .ex_m2reg_i(ex_m2reg), .ex_rn_i(ex_rn), .ex_alu_i(ex_alu),
    .mem_wreg_i(mem_wreg), .mem_m2reg_i(mem_m2reg), .mem_rn_i(mem_rn),
    .mem_alu_i(mem_alu), .mem_mo_i(mem_mo),
    .wb_wreg_i(wb_wreg), .wb_rn_i(wb_rn), .wb_d_i(wb_d),
    .d_o(fwd_a)
  );

  id_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .r_i(rt), .q_i(qb),
    .ex_wreg_i(ex_wreg), .ex_m2reg_i(ex_m2reg), .ex_rn_i(ex_rn), .ex_alu_i(ex_alu),
    .mem_wreg_i(mem_wreg), .mem_m2reg_i(mem_m2reg), .mem_rn_i(mem_rn),
    .mem_alu_i(mem_alu), .mem_mo_i(mem_mo),
    .wb_wreg_i(wb_wreg), .wb_rn_i(wb_rn), .wb_d_i(wb_d),
    .d_o(fwd_b)
  );

  // Unlisted opcodes/functs fall through the defaults and decode as a NOP.
  always_comb begin
    dec      = '0;
    dest     = rt;
    wr_en    = 1'b0;
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    use_sext = 1'b1;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    case (op)
      OP_RTYPE: begin
        dest    = rd;
        wr_en   = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        case (fn)
          FN_ADD:  dec.aluc = ALUC_ADD;
          FN_SUB:  dec.aluc = ALUC_SUB;
          FN_AND:  dec.aluc = ALUC_AND;
          FN_OR:   dec.aluc = ALUC_OR;
          FN_XOR:  dec.aluc = ALUC_XOR;
          FN_SLL:  begin dec.aluc = ALUC_SLL; dec.shift = 1'b1; uses_rs = 1'b0; end
          FN_SRL:  begin dec.aluc = ALUC_SRL; dec.shift = 1'b1; uses_rs = 1'b0; end
          FN_SRA:  begin dec.aluc = ALUC_SRA; dec.shift = 1'b1; uses_rs = 1'b0; end
          default: begin wr_en = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0; end
        endcase
      end
      OP_ADDI: begin wr_en = 1'b1; uses_rs = 1'b1; dec.aluimm = 1'b1; dec.aluc = ALUC_ADD; end
      OP_ANDI: begin wr_en = 1'b1; uses_rs = 1'b1; dec.aluimm = 1'b1; dec.aluc = ALUC_AND; use_sext = 1'b0; end
      OP_ORI:  begin wr_en = 1'b1; uses_rs = 1'b1; dec.aluimm = 1'b1; dec.aluc = ALUC_OR;  use_sext = 1'b0; end
      OP_XORI: begin wr_en = 1'b1; uses_rs = 1'b1; dec.aluimm = 1'b1; dec.aluc = ALUC_XOR; use_sext = 1'b0; end
      OP_LUI:  begin wr_en = 1'b1; dec.aluimm = 1'b1; dec.aluc = ALUC_LUI; use_sext = 1'b0; end
      OP_LW:   begin wr_en = 1'b1; uses_rs = 1'b1; dec.aluimm = 1'b1; dec.aluc = ALUC_ADD; dec.m2reg = 1'b1; end
      OP_SW:   begin uses_rs = 1'b1; uses_rt = 1'b1; dec.aluimm = 1'b1; dec.aluc = ALUC_ADD; dec.wmem = 1'b1; end
      OP_BEQ:  begin uses_rs = 1'b1; uses_rt = 1'b1; dec.aluc = ALUC_SUB; is_beq = 1'b1; end
      OP_BNE:  begin uses_rs = 1'b1; uses_rt = 1'b1; dec.aluc = ALUC_SUB; is_bne = 1'b1; end
      default: ;
    endcase
    dec.wreg = wr_en && (dest != '0);
  end

  assign stall = ex_wreg && ex_m2reg && (ex_rn != '0) &&
                 (((ex_rn == rs) && uses_rs) || ((ex_rn == rt) && uses_rt));

  assign br_taken  = !stall && ((is_beq && (fwd_a == fwd_b)) || (is_bne && (fwd_a != fwd_b)));
  assign br_target = pc4 + {sext_imm[DW-3:0], 2'b00};

  // A stalled cycle pushes an all-zero bubble; the same instruction re-decodes next cycle.
  always_comb begin
    ctrl_d = '0;
    a_d    = '0;
    b_d    = '0;
    imm_d  = '0;
    rn_d   = '0;
    pc4_d  = '0;
    if (!stall) begin
      ctrl_d = dec;
      a_d    = dec.shift ? {{(DW-5){1'b0}}, inst[10:6]} : fwd_a;
      b_d    = fwd_b;
      imm_d  = imm_ext;
      rn_d   = dest;
      pc4_d  = pc4;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      imm_q  <= '0;
      rn_q   <= '0;
      pc4_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      a_q    <= a_d;
      b_q    <= b_d;
      imm_q  <= imm_d;
      rn_q   <= rn_d;
      pc4_q  <= pc4_d;
    end
  end

  assign e_wreg   = ctrl_q.wreg;
  assign e_m2reg  = ctrl_q.m2reg;
  assign e_wmem   = ctrl_q.wmem;
  assign e_aluimm = ctrl_q.aluimm;
  assign e_shift  = ctrl_q.shift;
  assign e_aluc   = ctrl_q.aluc;
  assign e_a      = a_q;
  assign e_b      = b_q;
  assign e_imm    = imm_q;
  assign e_rn     = rn_q;
  assign e_pc4    = pc4_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed checks of the decode stage: decode, forwarding priority, load-use
// stall, branch resolution, r0 handling and asynchronous reset.
module tb_id_stage;

  logic        clk, clrn;
  logic [31:0] inst, pc4, qa, qb, ex_alu, mem_alu, mem_mo, wb_d;
  logic [4:0]  rna, rnb, ex_rn, mem_rn, wb_rn, e_rn;
  logic        ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, wb_wreg;
  logic        stall, br_taken;
  logic [31:0] br_target, e_a, e_b, e_imm, e_pc4;
  logic        e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift;
  logic [3:0]  e_aluc;

  int checks = 0;
  int errors = 0;

  id_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .clrn(clrn), .inst(inst), .pc4(pc4), .rna(rna), .rnb(rnb),
    .qa(qa), .qb(qb),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_alu(ex_alu),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
    .mem_alu(mem_alu), .mem_mo(mem_mo),
    .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_d(wb_d),
    .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_aluimm(e_aluimm),
    .e_shift(e_shift), .e_aluc(e_aluc), .e_a(e_a), .e_b(e_b), .e_imm(e_imm),
    .e_rn(e_rn), .e_pc4(e_pc4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_inst(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Driver tasks
  task automatic clear_inputs();
    inst = 32'h0; pc4 = 32'h0; qa = 32'h0; qb = 32'h0;
    ex_wreg = 0; ex_m2reg = 0; ex_rn = 0; ex_alu = 32'h0;
    mem_wreg = 0; mem_m2reg = 0; mem_rn = 0; mem_alu = 32'h0; mem_mo = 32'h0;
    wb_wreg = 0; wb_rn = 0; wb_d = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    clear_inputs();
    inst = r_inst(5'd1, 5'd2, 5'd10, 5'd0, 6'h20);
    repeat (2) step();
    checks++;
    if ({e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_aluc, e_a, e_b, e_imm, e_rn, e_pc4} !== '0) begin
      errors++; $display("FAIL reset_idex: got ctrl=%b a=%h pc4=%h required all zero",
                         {e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_aluc}, e_a, e_pc4);
    end
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_add();
    clear_inputs();
    inst = r_inst(5'd1, 5'd2, 5'd10, 5'd0, 6'h20); qa = 32'd1; qb = 32'd2; pc4 = 32'h40;
    #1;
    checks++;
    if ({rna, rnb} !== {5'd1, 5'd2}) begin
      errors++; $display("FAIL add_rfaddr: got %0d/%0d required 1/2", rna, rnb);
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL add_stall: got %b required 0", stall); end
    step();
    checks++;
    if ({e_a, e_b, e_rn, e_aluc, e_wreg} !== {32'd1, 32'd2, 5'd10, 4'b0000, 1'b1}) begin
      errors++; $display("FAIL add_idex: got a=%h b=%h rn=%0d aluc=%b wreg=%b required 1 2 10 0000 1",
                         e_a, e_b, e_rn, e_aluc, e_wreg);
    end
    checks++;
    if (e_pc4 !== 32'h40) begin errors++; $display("FAIL add_pc4: got %h required 00000040", e_pc4); end
  endtask

  task automatic test_fwd_ex();
    clear_inputs();
    inst = i_inst(6'h08, 5'd1, 5'd4, 16'hFFFD); qa = 32'd1;
    ex_wreg = 1; ex_rn = 5'd1; ex_alu = 32'h55;
    step();
    checks++;
    if ({e_a, e_imm, e_aluimm, e_rn} !== {32'h55, 32'hFFFFFFFD, 1'b1, 5'd4}) begin
      errors++; $display("FAIL addi_ex_fwd: got a=%h imm=%h aluimm=%b rn=%0d required 55 fffffffd 1 4",
                         e_a, e_imm, e_aluimm, e_rn);
    end
    mem_wreg = 1; mem_rn = 5'd1; mem_alu = 32'h99; wb_wreg = 1; wb_rn = 5'd1; wb_d = 32'h77;
    step();
    checks++;
    if (e_a !== 32'h55) begin errors++; $display("FAIL ex_over_mem: got %h required 00000055", e_a); end
    ex_wreg = 0;
    step();
    checks++;
    if (e_a !== 32'h99) begin errors++; $display("FAIL mem_alu_over_wb: got %h required 00000099", e_a); end
    inst = i_inst(6'h0C, 5'd1, 5'd6, 16'h8001);
    step();
    checks++;
    if ({e_imm, e_aluc} !== {32'h00008001, 4'b0001}) begin
      errors++; $display("FAIL andi_zext: got imm=%h aluc=%b required 00008001 0001", e_imm, e_aluc);
    end
    inst = i_inst(6'h0F, 5'd0, 5'd5, 16'h1234);
    step();
    checks++;
    if ({e_imm, e_aluc, e_aluimm, e_wreg, e_rn} !== {32'h00001234, 4'b0110, 1'b1, 1'b1, 5'd5}) begin
      errors++; $display("FAIL lui_decode: got imm=%h aluc=%b aluimm=%b wreg=%b rn=%0d required 1234 0110 1 1 5",
                         e_imm, e_aluc, e_aluimm, e_wreg, e_rn);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 5'd3;
    inst = r_inst(5'd3, 5'd2, 5'd5, 5'd0, 6'h22); qa = 32'hDEAD; qb = 32'd9;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %b required 1", stall); end
    step();
    checks++;
    if ({e_wreg, e_wmem, e_m2reg, e_aluc, e_rn} !== '0) begin
      errors++; $display("FAIL loaduse_bubble: got wreg=%b wmem=%b aluc=%b rn=%0d required zeros",
                         e_wreg, e_wmem, e_aluc, e_rn);
    end
    ex_wreg = 0; ex_m2reg = 0;
    mem_wreg = 1; mem_m2reg = 1; mem_rn = 5'd3; mem_mo = 32'h1234; mem_alu = 32'hBAD;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL loaduse_release: got %b required 0", stall); end
    step();
    checks++;
    if ({e_a, e_b, e_aluc, e_wreg, e_rn} !== {32'h1234, 32'd9, 4'b0100, 1'b1, 5'd5}) begin
      errors++; $display("FAIL mem_mo_fwd: got a=%h b=%h aluc=%b wreg=%b rn=%0d required 1234 9 0100 1 5",
                         e_a, e_b, e_aluc, e_wreg, e_rn);
    end
    // Shift with rs field matching a load in EX: shifts ignore rs, so no stall.
    clear_inputs();
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 5'd3;
    inst = r_inst(5'd3, 5'd2, 5'd8, 5'd4, 6'h00); qb = 32'h3;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL shift_no_rs_stall: got %b required 0", stall); end
    step();
    checks++;
    if ({e_a, e_b, e_shift, e_aluc, e_rn} !== {32'd4, 32'd3, 1'b1, 4'b0011, 5'd8}) begin
      errors++; $display("FAIL sll_decode: got a=%h b=%h shift=%b aluc=%b rn=%0d required 4 3 1 0011 8",
                         e_a, e_b, e_shift, e_aluc, e_rn);
    end
    // Load into rt of lw's own base-only use: lw does not read rt, no stall.
    inst = i_inst(6'h23, 5'd1, 5'd3, 16'h0004);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lw_rt_no_stall: got %b required 0", stall); end
    // Load into r0 never stalls.
    ex_rn = 5'd0; inst = r_inst(5'd0, 5'd0, 5'd5, 5'd0, 6'h20);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL loaduse_r0: got %b required 0", stall); end
  endtask

  task automatic test_branch();
    clear_inputs();
    inst = i_inst(6'h04, 5'd6, 5'd7, 16'd4); pc4 = 32'h100;
    wb_wreg = 1; wb_rn = 5'd6; wb_d = 32'd7; qa = 32'd0; qb = 32'd7;
    #1;
    checks++;
    if ({br_taken, br_target} !== {1'b1, 32'h110}) begin
      errors++; $display("FAIL beq_taken: got taken=%b target=%h required 1 00000110", br_taken, br_target);
    end
    inst = i_inst(6'h05, 5'd6, 5'd7, 16'd4);
    #1;
    checks++;
    if (br_taken !== 1'b0) begin errors++; $display("FAIL bne_not_taken: got %b required 0", br_taken); end
    qb = 32'd8;
    #1;
    checks++;
    if (br_taken !== 1'b1) begin errors++; $display("FAIL bne_taken: got %b required 1", br_taken); end
    inst = i_inst(6'h04, 5'd6, 5'd7, 16'hFFFF); qb = 32'd7;
    #1;
    checks++;
    if ({br_taken, br_target} !== {1'b1, 32'hFC}) begin
      errors++; $display("FAIL beq_back: got taken=%b target=%h required 1 000000fc", br_taken, br_target);
    end
    step();
    checks++;
    if ({e_wreg, e_wmem} !== 2'b00) begin
      errors++; $display("FAIL beq_nowrite: got wreg=%b wmem=%b required 0 0", e_wreg, e_wmem);
    end
    // Branch operand pending on a load: stall and suppress the branch.
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 5'd7;
    #1;
    checks++;
    if ({stall, br_taken} !== 2'b10) begin
      errors++; $display("FAIL beq_stall_suppress: got stall=%b taken=%b required 1 0", stall, br_taken);
    end
  endtask

  task automatic test_r0();
    clear_inputs();
    wb_wreg = 1; wb_rn = 5'd0; wb_d = 32'hFF;
    ex_wreg = 1; ex_rn = 5'd0; ex_alu = 32'hAA;
    inst = r_inst(5'd0, 5'd0, 5'd9, 5'd0, 6'h25); qa = 32'h77; qb = 32'h66;
    step();
    checks++;
    if ({e_a, e_b} !== {32'h0, 32'h0}) begin
      errors++; $display("FAIL r0_operand: got a=%h b=%h required 0 0", e_a, e_b);
    end
    clear_inputs();
    inst = i_inst(6'h08, 5'd1, 5'd0, 16'd5);
    step();
    checks++;
    if (e_wreg !== 1'b0) begin errors++; $display("FAIL r0_dest_wreg: got %b required 0", e_wreg); end
    inst = i_inst(6'h2B, 5'd1, 5'd2, 16'd8); qa = 32'h10; qb = 32'hCAFE;
    step();
    checks++;
    if ({e_wmem, e_wreg, e_b, e_imm, e_a} !== {1'b1, 1'b0, 32'hCAFE, 32'd8, 32'h10}) begin
      errors++; $display("FAIL sw_decode: got wmem=%b wreg=%b b=%h imm=%h a=%h required 1 0 cafe 8 10",
                         e_wmem, e_wreg, e_b, e_imm, e_a);
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    inst = r_inst(5'd1, 5'd2, 5'd10, 5'd0, 6'h26); qa = 32'h5; qb = 32'h6; pc4 = 32'h200;
    step();
    checks++;
    if ({e_wreg, e_aluc, e_pc4} !== {1'b1, 4'b0010, 32'h200}) begin
      errors++; $display("FAIL xor_pre_reset: got wreg=%b aluc=%b pc4=%h required 1 0010 200",
                         e_wreg, e_aluc, e_pc4);
    end
    #2 clrn = 1'b0;
    #1;
    checks++;
    if ({e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_aluc, e_a, e_b, e_imm, e_rn, e_pc4} !== '0) begin
      errors++; $display("FAIL async_reset: got wreg=%b a=%h pc4=%h required all zero", e_wreg, e_a, e_pc4);
    end
    #1 clrn = 1'b1;
  endtask

  task automatic test_undefined();
    clear_inputs();
    inst = i_inst(6'h3F, 5'd1, 5'd2, 16'h1234);
    step();
    checks++;
    if ({e_wreg, e_m2reg, e_wmem} !== 3'b000) begin
      errors++; $display("FAIL undef_op: got wreg=%b m2reg=%b wmem=%b required 000", e_wreg, e_m2reg, e_wmem);
    end
    inst = r_inst(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F);
    step();
    checks++;
    if ({e_wreg, e_m2reg, e_wmem} !== 3'b000) begin
      errors++; $display("FAIL undef_funct: got wreg=%b m2reg=%b wmem=%b required 000", e_wreg, e_m2reg, e_wmem);
    end
  endtask

  // Scenario sequence and report
  initial begin
    test_reset();
    test_add();
    test_fwd_ex();
    test_load_use();
    test_branch();
    test_r0();
    test_async_reset();
    test_undefined();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
